glb_block_stream_tx: RTL and testbench
======================================

Name: glb_block_stream_tx

Overview:
- Synthesizable GLB-side transmitter for the 17-bit block-mode stream consumed by the fiber-access write scanner's block_wr_in port.
- Host logic loads payload words and closes blocks; the block emits each block as a length header followed by its payload.
- After the host signals end-of-stream, it emits the done token and raises done.
- Replaces the behavioural stream-write driver with RTL usable in GLB tiles and in benches.

Parameters:
- DATA_W, 16, payload/header width; output is DATA_W+1 bits, MSB = control flag.
- DEPTH, 256, payload FIFO entries (power of 2).
- LEN_DEPTH, 4, closed-block length FIFO entries (power of 2).
- DONE_TOKEN, 17'h10100, token emitted after the last block.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous clear of all state; same effect as rst.
- load_data  in  DATA_W  payload word.
- load_valid  in  1  payload word valid.
- load_ready  out  1  payload word accepted when valid&ready.
- blk_close  in  1  pulse: close current open block (may coincide with a load beat; that beat belongs to the block).
- blk_close_ready  out  1  length FIFO not full.
- stream_end  in  1  pulse: no further blocks; latched.
- out_data  out  DATA_W+1  stream word.
- out_valid  out  1  stream valid.
- out_ready  in  1  downstream ready.
- done  out  1  done token handshaken.
- stall_count  out  32  cycles with out_valid&~out_ready (see Optional Feature).

Behaviour:
- Reset/flush: out_valid=0, out_data=0, done=0, FIFOs empty, open count=0, end latch=0, FSM=IDLE, stall_count=0.
- Load:
  - load_ready = ~data_full & blk_close_ready & ~end_latched & ~done.
  - Accepted beat pushes the payload FIFO and increments open_cnt (width log2(DEPTH)+1).
- Close:
  - blk_close with blk_close_ready pushes the length value into the length FIFO and clears open_cnt.
  - The length value is open_cnt, plus 1 if a beat is accepted in the same cycle.
  - Zero-length blocks are legal.
  - blk_close while ~blk_close_ready is ignored; the host must hold it.
- stream_end: sets end_latched.
  - If open_cnt>0 at latch time, the block is closed implicitly when the length FIFO has room (before the done token).
- FSM states: IDLE, HDR, DATA, DONE_TOK, FINISHED.
  - IDLE: if length FIFO non-empty, pop it and load out_data={1'b0,len}, out_valid=1, go to HDR.
  - IDLE: else if end_latched & open_cnt==0, load out_data=DONE_TOKEN, go to DONE_TOK.
  - HDR: on handshake, if len==0 go to IDLE; else present the first payload word and go to DATA with remaining=len.
  - DATA: each handshake decrements remaining and presents the next word. After the last word's handshake, go to IDLE with out_valid=0.
  - DONE_TOK: on handshake, out_valid=0, done=1, go to FINISHED.
  - FINISHED: sticky until rst/flush; all inputs ignored.
- Output is registered.
  - out_data/out_valid must hold stable while out_valid&~out_ready.
  - Sustained 1 word/cycle inside a block.
  - One idle bubble cycle is permitted between blocks.
- Payload FIFO never underflows in DATA, because headers are issued only for closed (fully loaded) blocks.
- Simultaneous load push and DATA pop in the same cycle: both take effect, and count is unchanged.
- Latency: first header valid 1 cycle after the blk_close that fills an empty length FIFO while IDLE.
- Async rst mid-transfer: immediate out_valid=0; no partial block is resumed.

Optional Feature:
- Macro GLB_BLOCK_TX_STALL_CNT_EN.
- Defined: stall_count increments each cycle with out_valid&~out_ready, saturates at 2^32-1, and clears on rst/flush.
- Undefined: stall_count tied to 0 and no counter logic is synthesized.

Test Plan:
- Load 3 words (5,6,7) with blk_close on the 3rd, then stream_end, out_ready=1 -> stream 0x00003, 5, 6, 7, 0x10100; done=1 the cycle after the token handshake.
- blk_close with no data, then stream_end -> 0x00000, 0x10100, done.
- Four 2-word blocks closed back-to-back with out_ready=0 -> blk_close_ready drops after the 4th. Releasing out_ready -> 4 headers of 0x00002 with correct payload order.
- Random out_ready backpressure over a 100-word block -> out_data stable during stalls and no word lost or duplicated. With the macro defined, stall_count equals the number of stalled cycles.
- stream_end with an open 2-word block (9,10) -> implicit close; output 0x00002, 9, 10, 0x10100.
- Assert rst mid-DATA, then repeat the first scenario -> out_valid=0 immediately, and the clean stream after reset matches the first scenario exactly.

Source files
------------

// File: rtl/glb_block_stream_tx.sv
// glb_block_stream_tx: GLB-side transmitter for the 17-bit block-mode stream.
// Host loads payload words and closes blocks; each closed block is sent as a
// length header {1'b0,len} followed by its payload. After stream_end the done
// token is sent and done is raised (sticky until rst/flush).
// Ports:
//   clk, rst (async active-high), flush (sync clear, same effect as rst)
//   load_data/load_valid/load_ready : payload word input handshake
//   blk_close/blk_close_ready       : close the open block (pulse, hold if not ready)
//   stream_end                      : pulse, latched; no further blocks
//   out_data/out_valid/out_ready    : registered output stream, MSB = control flag
//   done                            : done token handshaken
//   stall_count                     : cycles with out_valid&~out_ready
// Optional: define GLB_BLOCK_TX_STALL_CNT_EN to build the saturating stall counter;
// otherwise stall_count is tied to zero.
module glb_block_stream_tx #(
    parameter int              DATA_W     = 16,
    parameter int              DEPTH      = 256,
    parameter int              LEN_DEPTH  = 4,
    parameter logic [DATA_W:0] DONE_TOKEN = 17'h10100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              blk_close,
    output logic              blk_close_ready,
    input  logic              stream_end,
    output logic [DATA_W:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic [31:0]       stall_count
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = $clog2(LEN_DEPTH);
    localparam int CW  = AW + 1;
    localparam int LCW = LW + 1;

    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE_TOK, FINISHED} state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CW-1:0]     len_mem_q [LEN_DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q;
    logic [LW-1:0]     lwr_q, lrd_q;
    logic [LCW-1:0]    lcnt_q;
    logic [CW-1:0]     open_q, rem_q, rem_d;
    logic              end_q;
    state_t            state_q, state_d;
    logic [DATA_W:0]   out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d, done_q, done_d;
    logic              data_full, len_full, len_empty, load_fire, close_fire, hs;
    logic              pop_data, pop_len;
    logic [CW-1:0]     close_len, hdr_len;

    assign data_full       = cnt_q == CW'(DEPTH);
    assign len_full        = lcnt_q == LCW'(LEN_DEPTH);
    assign len_empty       = lcnt_q == '0;
    assign blk_close_ready = ~len_full;
    assign load_ready      = ~data_full & ~len_full & ~end_q & ~done_q;
    assign load_fire       = load_valid & load_ready;
    // Explicit closes stop at stream_end; afterwards a non-empty open block closes itself.
    assign close_fire      = ~len_full & ~done_q & ((blk_close & ~end_q) | (end_q & (open_q != '0)));
    assign close_len       = open_q + CW'(load_fire);
    // A close landing in an empty length FIFO is forwarded straight to the header.
    assign hdr_len         = len_empty ? close_len : len_mem_q[lrd_q];
    assign hs              = out_valid_q & out_ready;
    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign done            = done_q;

    // The length entry stays queued until its block finishes, so the FIFO
    // counts every closed block not yet fully sent.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = done_q;
        rem_d       = rem_q;
        pop_data    = 1'b0;
        pop_len     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!len_empty || close_fire) begin
                    out_data_d  = {1'b0, DATA_W'(hdr_len)};
                    out_valid_d = 1'b1;
                    rem_d       = hdr_len;
                    state_d     = HDR;
                end else if (end_q && open_q == '0) begin
                    out_data_d  = DONE_TOKEN;
                    out_valid_d = 1'b1;
                    state_d     = DONE_TOK;
                end
            end
            HDR: begin
                if (hs) begin
                    if (rem_q == '0) begin
                        out_valid_d = 1'b0;
                        pop_len     = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        out_data_d = {1'b0, mem_q[rd_q]};
                        pop_data   = 1'b1;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (hs) begin
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        out_valid_d = 1'b0;
                        pop_len     = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        out_data_d = {1'b0, mem_q[rd_q]};
                        pop_data   = 1'b1;
                    end
                end
            end
            DONE_TOK: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = FINISHED;
                end
            end
            FINISHED: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load_fire) mem_q[wr_q] <= load_data;
        if (close_fire) len_mem_q[lwr_q] <= close_len;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE; out_data_q <= '0; out_valid_q <= 1'b0; done_q <= 1'b0;
            rem_q <= '0; open_q <= '0; end_q <= 1'b0;
            wr_q <= '0; rd_q <= '0; cnt_q <= '0; lwr_q <= '0; lrd_q <= '0; lcnt_q <= '0;
        end else if (flush) begin
            state_q <= IDLE; out_data_q <= '0; out_valid_q <= 1'b0; done_q <= 1'b0;
            rem_q <= '0; open_q <= '0; end_q <= 1'b0;
            wr_q <= '0; rd_q <= '0; cnt_q <= '0; lwr_q <= '0; lrd_q <= '0; lcnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            rem_q       <= rem_d;
            open_q      <= close_fire ? '0 : open_q + CW'(load_fire);
            end_q       <= end_q | stream_end;
            wr_q        <= wr_q + AW'(load_fire);
            rd_q        <= rd_q + AW'(pop_data);
            cnt_q       <= cnt_q + CW'(load_fire) - CW'(pop_data);
            lwr_q       <= lwr_q + LW'(close_fire);
            lrd_q       <= lrd_q + LW'(pop_len);
            lcnt_q      <= lcnt_q + LCW'(close_fire) - LCW'(pop_len);
        end
    end

`ifdef GLB_BLOCK_TX_STALL_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else if (flush) stall_q <= '0;
        else if (out_valid_q && !out_ready && !(&stall_q)) stall_q <= stall_q + 32'd1;
    end
    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_glb_block_stream_tx.sv
// tb_glb_block_stream_tx: directed self-checking bench for glb_block_stream_tx.
module tb_glb_block_stream_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        blk_close = 1'b0;
    logic        blk_close_ready;
    logic        stream_end = 1'b0;
    logic [16:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic [31:0] stall_count;
    logic        rdy = 1'b1;
    logic        bp_en = 1'b0;
    logic        bp_rnd = 1'b1;

    int          checks = 0;
    int          failures = 0;
    logic [16:0] got[$];
    logic [16:0] exp_q[$];
    int          base = 0;
    int          n_stall = 0;
    int          stall_base = 0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_data = '0;

    localparam logic [16:0] TOK = 17'h10100;

    assign out_ready = bp_en ? bp_rnd : rdy;

    glb_block_stream_tx dut (
        .clk(clk), .rst(rst), .flush(flush),
        .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
        .blk_close(blk_close), .blk_close_ready(blk_close_ready),
        .stream_end(stream_end),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .done(done), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bp_rnd = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stab_err++;
            if (out_valid && !out_ready) n_stall++;
            if (out_valid && out_ready) got.push_back(out_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        base = got.size();
        stall_base = n_stall;
    endtask

    task automatic load(input logic [15:0] w, input logic c);
        int n;
        load_data = w;
        load_valid = 1'b1;
        blk_close = c;
        n = 0;
        while (!load_ready && n < 200) begin
            tick;
            n++;
        end
        chk("load_ready", 32'(load_ready), 32'd1);
        tick;
        load_valid = 1'b0;
        blk_close = 1'b0;
    endtask

    task automatic end_pulse;
        stream_end = 1'b1;
        tick;
        stream_end = 1'b0;
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (!done && n < 3000) begin
            tick;
            n++;
        end
        chk("done", 32'(done), 32'd1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, 32'(got.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < got.size()) chk(tag, 32'(got[base + i]), 32'(exp_q[i]));
    endtask

    task automatic run_s1(input string tag);
        int n;
        rdy = 1'b1;
        load(16'd5, 1'b0);
        load(16'd6, 1'b0);
        load(16'd7, 1'b1);
        chk({tag, "_hdr_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_hdr_data"}, 32'(out_data), 32'h3);
        end_pulse;
        n = 0;
        while (!(out_valid && out_data == TOK) && n < 100) begin
            tick;
            n++;
        end
        chk({tag, "_tok_seen"}, 32'(out_valid && out_data == TOK), 32'd1);
        chk({tag, "_done_pre"}, 32'(done), 32'd0);
        tick;
        chk({tag, "_done_post"}, 32'(done), 32'd1);
        chk({tag, "_valid_post"}, 32'(out_valid), 32'd0);
        chk({tag, "_load_ready_fin"}, 32'(load_ready), 32'd0);
        exp_q = {17'h3, 17'd5, 17'd6, 17'd7, TOK};
        check_stream(tag);
    endtask

    initial begin
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", stall_count, 32'd0);
        reset_dut;
        chk("idle_load_ready", 32'(load_ready), 32'd1);
        chk("idle_close_ready", 32'(blk_close_ready), 32'd1);
        chk("idle_valid", 32'(out_valid), 32'd0);

        run_s1("s1");

        reset_dut;
        blk_close = 1'b1;
        tick;
        blk_close = 1'b0;
        chk("s2_hdr", 32'(out_data), 32'h0);
        end_pulse;
        wait_done;
        exp_q = {17'h0, TOK};
        check_stream("s2");

        reset_dut;
        rdy = 1'b0;
        for (int b = 0; b < 4; b++) begin
            load(16'(2 * b + 1), 1'b0);
            load(16'(2 * b + 2), 1'b1);
        end
        chk("s3_close_ready", 32'(blk_close_ready), 32'd0);
        chk("s3_load_ready", 32'(load_ready), 32'd0);
        chk("s3_hold_data", 32'(out_data), 32'h2);
        rdy = 1'b1;
        end_pulse;
        wait_done;
        exp_q = {17'h2, 17'd1, 17'd2, 17'h2, 17'd3, 17'd4, 17'h2, 17'd5, 17'd6, 17'h2, 17'd7, 17'd8, TOK};
        check_stream("s3");

        reset_dut;
        bp_en = 1'b1;
        exp_q.delete();
        exp_q.push_back(17'h64);
        for (int i = 0; i < 100; i++) begin
            load(16'(200 + i), i == 99);
            exp_q.push_back(17'(200 + i));
        end
        exp_q.push_back(TOK);
        end_pulse;
        wait_done;
        bp_en = 1'b0;
        check_stream("s4");
        chk("s4_stable", 32'(stab_err), 32'd0);
`ifdef GLB_BLOCK_TX_STALL_CNT_EN
        chk("s4_stall_count", stall_count, 32'(n_stall - stall_base));
`else
        chk("s4_stall_count_off", stall_count, 32'd0);
`endif

        reset_dut;
        rdy = 1'b1;
        load(16'd9, 1'b0);
        load(16'd10, 1'b0);
        end_pulse;
        wait_done;
        exp_q = {17'h2, 17'd9, 17'd10, TOK};
        check_stream("s5");

        reset_dut;
        rdy = 1'b0;
        load(16'd5, 1'b0);
        load(16'd6, 1'b0);
        load(16'd7, 1'b1);
        rdy = 1'b1;
        tick;
        tick;
        rdy = 1'b0;
        chk("s6_mid_data", 32'(out_data), 32'd6);
        #3;
        rst = 1'b1;
        #1;
        chk("s6_async_valid", 32'(out_valid), 32'd0);
        chk("s6_async_data", 32'(out_data), 32'd0);
        tick;
        rst = 1'b0;
        base = got.size();
        stall_base = n_stall;
        run_s1("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
